// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, reset defaults and control codes
// used by the fetch stage, next-PC logic and decode.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_ERR  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT       = 32'd0;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 16;

  localparam logic [10:0] BRANCH      = 11'd31;
  localparam logic [10:0] BRANCH_LINK = 11'd32;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pc_fetch_stage_if.sv
// Instruction-memory and decode-side signals of the fetch stage.
// Handshake rule for every channel: a transfer happens on a rising edge where
// valid and ready are both 1; valid never depends combinationally on ready.
interface pc_fetch_stage_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rsp_valid;
    logic [31:0]       imem_rsp_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst_out;
    logic [31:0]       inst_pc;

    modport master (
        output imem_req_valid, imem_addr, inst_valid, inst_out, inst_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr, inst_valid, inst_out, inst_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
    );
endinterface

// File: rtl/fetch_timeout_counter.sv
// Counts cycles spent waiting for an imem response; terminal_o flags the
// last permitted waiting cycle.
module fetch_timeout_counter
    import cpu_pkg::*;
#(
    parameter int unsigned LIMIT = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic terminal_o
);
    localparam int unsigned   CW   = cnt_width(LIMIT);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign terminal_o = (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !terminal_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/pc_fetch_stage.sv
// Holds the architectural PC and performs one non-pipelined instruction fetch
// at a time, handing each instruction and its PC to decode.
module pc_fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = RESET_PC_DEFAULT,
    parameter int          ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    output logic [31:0]     program_counter,
    input  logic [31:0]     program_counter_next,
    input  logic            halt,
    output logic            fetch_error,
    output fetch_state_e    dbg_state_o,
    pc_fetch_stage_if.master bus
);
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  inst_pc_q, inst_pc_d;
    logic         req_valid;
    logic         inst_valid;
    logic         timeout_hit;

    fetch_timeout_counter #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (state_q != S_WAIT),
        .enable_i   ((state_q == S_WAIT) && !bus.imem_rsp_valid),
        .terminal_o (timeout_hit)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        req_valid  = 1'b0;
        inst_valid = 1'b0;
        case (state_q)
            S_REQ: begin
                req_valid = !halt;
                if (req_valid && bus.imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response in the limit cycle still wins over the fault.
                if (bus.imem_rsp_valid) begin
                    inst_d    = bus.imem_rsp_data;
                    inst_pc_d = pc_q;
                    state_d   = S_HOLD;
                end else if (timeout_hit) begin
                    state_d = S_ERR;
                end
            end
            S_HOLD: begin
                inst_valid = 1'b1;
                if (bus.inst_ready) begin
                    pc_d    = program_counter_next;
                    state_d = S_REQ;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
        if (reset) begin
            req_valid  = 1'b0;
            inst_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            inst_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

    assign program_counter    = pc_q;
    assign fetch_error        = (state_q == S_ERR);
    assign dbg_state_o        = state_q;
    assign bus.imem_req_valid = req_valid;
    assign bus.imem_addr      = pc_q[ADDR_W-1:0];
    assign bus.inst_valid     = inst_valid;
    assign bus.inst_out       = inst_q;
    assign bus.inst_pc        = inst_pc_q;
endmodule

// File: tb/tb_pc_fetch_stage.sv
// Bench for pc_fetch_stage: directed scenarios plus a randomized run checked
// against a transaction-level model of the fetch/decode protocol.
module tb_pc_fetch_stage;
    import cpu_pkg::*;

    localparam int unsigned TIMEOUT = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  program_counter;
    logic [31:0]  program_counter_next;
    logic         halt;
    logic         fetch_error;
    fetch_state_e dbg_state;
    logic [31:0]  npc_off;

    int tests_run    = 0;
    int tests_failed = 0;

    // {pc, instruction} of each instruction expected at decode, in order
    logic [63:0] exp_q[$];

    pc_fetch_stage_if #(.ADDR_W(32)) bus_if ();

    pc_fetch_stage #(
        .RESET_PC       (32'd0),
        .ADDR_W         (32),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .program_counter      (program_counter),
        .program_counter_next (program_counter_next),
        .halt                 (halt),
        .fetch_error          (fetch_error),
        .dbg_state_o          (dbg_state),
        .bus                  (bus_if)
    );

    // Stand-in next-PC logic: current PC plus a bench-chosen offset.
    assign program_counter_next = program_counter + npc_off;

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        halt                  = 1'b0;
        bus_if.imem_req_ready = 1'b0;
        bus_if.imem_rsp_valid = 1'b0;
        bus_if.imem_rsp_data  = 32'd0;
        bus_if.inst_ready     = 1'b0;
        npc_off               = 32'd1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    // Issue one fetch with a zero-wait response; returns in the HOLD cycle.
    task automatic run_to_hold(input logic [31:0] data, output bit ok);
        int n = 0;
        ok = 1'b0;
        bus_if.imem_req_ready = 1'b1;
        bus_if.imem_rsp_valid = 1'b0;
        bus_if.inst_ready     = 1'b0;
        #1;
        while (bus_if.imem_req_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 20) return;
        @(negedge clk);
        bus_if.imem_req_ready = 1'b0;
        bus_if.imem_rsp_valid = 1'b1;
        bus_if.imem_rsp_data  = data;
        @(negedge clk);
        bus_if.imem_rsp_valid = 1'b0;
        #1;
        ok = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        #1;
        tests_run++; if (bus_if.imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_req_forced: got %b want 0", bus_if.imem_req_valid); end
        tests_run++; if (bus_if.inst_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_inst_forced: got %b want 0", bus_if.inst_valid); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests_run++; if (program_counter !== 32'd0) begin tests_failed++; $display("FAIL rst_pc: got %h want 0", program_counter); end
        tests_run++; if (bus_if.imem_req_valid !== 1'b1) begin tests_failed++; $display("FAIL rst_req: got %b want 1", bus_if.imem_req_valid); end
        tests_run++; if (bus_if.imem_addr !== 32'd0) begin tests_failed++; $display("FAIL rst_addr: got %h want 0", bus_if.imem_addr); end
        tests_run++; if (bus_if.inst_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_inst_valid: got %b want 0", bus_if.inst_valid); end
        tests_run++; if (bus_if.inst_out !== 32'd0) begin tests_failed++; $display("FAIL rst_inst_out: got %h want 0", bus_if.inst_out); end
        tests_run++; if (bus_if.inst_pc !== 32'd0) begin tests_failed++; $display("FAIL rst_inst_pc: got %h want 0", bus_if.inst_pc); end
        tests_run++; if (fetch_error !== 1'b0) begin tests_failed++; $display("FAIL rst_err: got %b want 0", fetch_error); end
        tests_run++; if (dbg_state !== S_REQ) begin tests_failed++; $display("FAIL rst_state: got %0d want %0d", dbg_state, S_REQ); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] idx;
        do_reset();
        bus_if.imem_req_ready = 1'b1;
        bus_if.imem_rsp_valid = 1'b1;
        bus_if.imem_rsp_data  = 32'hE3A0_0001;
        bus_if.inst_ready     = 1'b1;
        npc_off               = 32'd1;
        #1;
        for (int c = 0; c < 9; c++) begin
            idx = 32'(c / 3);
            tests_run++; if (bus_if.imem_req_valid !== (c % 3 == 0)) begin tests_failed++; $display("FAIL zw_req c=%0d: got %b", c, bus_if.imem_req_valid); end
            tests_run++; if (bus_if.inst_valid !== (c % 3 == 2)) begin tests_failed++; $display("FAIL zw_inst_valid c=%0d: got %b", c, bus_if.inst_valid); end
            if (c % 3 == 0) begin
                tests_run++; if (bus_if.imem_addr !== idx) begin tests_failed++; $display("FAIL zw_addr c=%0d: got %h want %h", c, bus_if.imem_addr, idx); end
            end
            if (c % 3 == 2) begin
                tests_run++; if (bus_if.inst_pc !== idx) begin tests_failed++; $display("FAIL zw_inst_pc c=%0d: got %h want %h", c, bus_if.inst_pc, idx); end
                tests_run++; if (bus_if.inst_out !== 32'hE3A0_0001) begin tests_failed++; $display("FAIL zw_inst_out c=%0d: got %h want e3a00001", c, bus_if.inst_out); end
            end
            @(negedge clk);
            #1;
        end
        idle_inputs();
    endtask

    task automatic test_branch();
        bit ok;
        logic [31:0] targets [4];
        logic [31:0] offs [4];
        targets[0] = 32'd234;        offs[0] = 32'd234;
        targets[1] = 32'd734;        offs[1] = 32'd500;
        targets[2] = 32'hFFFF_FFFF;  offs[2] = 32'hFFFF_FFFF - 32'd734;
        targets[3] = 32'd0;          offs[3] = 32'd1;
        do_reset();
        run_to_hold(32'h1111_0000, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL br_hold0: got no request want request"); end
        for (int i = 0; i < 4; i++) begin
            npc_off           = offs[i];
            bus_if.inst_ready = 1'b1;
            @(negedge clk);
            bus_if.inst_ready = 1'b0;
            #1;
            tests_run++; if (program_counter !== targets[i]) begin tests_failed++; $display("FAIL br_pc%0d: got %h want %h", i, program_counter, targets[i]); end
            tests_run++; if (bus_if.imem_addr !== targets[i]) begin tests_failed++; $display("FAIL br_addr%0d: got %h want %h", i, bus_if.imem_addr, targets[i]); end
            run_to_hold(32'h2222_0000 + 32'(i), ok);
            tests_run++; if (!ok || bus_if.inst_pc !== targets[i]) begin tests_failed++; $display("FAIL br_inst_pc%0d: got %h want %h", i, bus_if.inst_pc, targets[i]); end
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [31:0] d;
        d = $urandom;
        do_reset();
        run_to_hold(d, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL bp_hold: got no request want request"); end
        npc_off = 32'd1;
        for (int k = 0; k < 5; k++) begin
            bus_if.imem_rsp_valid = 1'b1;
            bus_if.imem_rsp_data  = ~d;
            bus_if.inst_ready     = 1'b0;
            #1;
            tests_run++; if (bus_if.inst_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_valid k=%0d: got %b want 1", k, bus_if.inst_valid); end
            tests_run++; if (bus_if.inst_out !== d) begin tests_failed++; $display("FAIL bp_out k=%0d: got %h want %h", k, bus_if.inst_out, d); end
            tests_run++; if (bus_if.inst_pc !== 32'd0) begin tests_failed++; $display("FAIL bp_inst_pc k=%0d: got %h want 0", k, bus_if.inst_pc); end
            tests_run++; if (program_counter !== 32'd0) begin tests_failed++; $display("FAIL bp_pc k=%0d: got %h want 0", k, program_counter); end
            tests_run++; if (bus_if.imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_req k=%0d: got %b want 0", k, bus_if.imem_req_valid); end
            @(negedge clk);
        end
        bus_if.imem_rsp_valid = 1'b0;
        bus_if.inst_ready     = 1'b1;
        @(negedge clk);
        bus_if.inst_ready = 1'b0;
        #1;
        tests_run++; if (program_counter !== 32'd1) begin tests_failed++; $display("FAIL bp_advance: got %h want 1", program_counter); end
        tests_run++; if (bus_if.imem_req_valid !== 1'b1 || bus_if.imem_addr !== 32'd1) begin tests_failed++; $display("FAIL bp_next_req: got %b/%h want 1/1", bus_if.imem_req_valid, bus_if.imem_addr); end
        idle_inputs();
    endtask

    task automatic test_timeout();
        logic [31:0] d;
        do_reset();
        bus_if.imem_req_ready = 1'b1;
        @(negedge clk);
        bus_if.imem_req_ready = 1'b0;
        #1;
        for (int k = 1; k <= int'(TIMEOUT); k++) begin
            tests_run++; if (fetch_error !== 1'b0) begin tests_failed++; $display("FAIL to_early k=%0d: got %b want 0", k, fetch_error); end
            @(negedge clk);
            #1;
        end
        tests_run++; if (fetch_error !== 1'b1) begin tests_failed++; $display("FAIL to_rise: got %b want 1", fetch_error); end
        tests_run++; if (dbg_state !== S_ERR) begin tests_failed++; $display("FAIL to_state: got %0d want %0d", dbg_state, S_ERR); end
        for (int k = 0; k < 6; k++) begin
            bus_if.imem_req_ready = 1'b1;
            bus_if.inst_ready     = 1'b1;
            bus_if.imem_rsp_valid = 1'($urandom_range(0, 1));
            bus_if.imem_rsp_data  = $urandom;
            #1;
            tests_run++; if (fetch_error !== 1'b1) begin tests_failed++; $display("FAIL to_sticky k=%0d: got %b want 1", k, fetch_error); end
            tests_run++; if (bus_if.imem_req_valid !== 1'b0 || bus_if.inst_valid !== 1'b0) begin tests_failed++; $display("FAIL to_valids k=%0d: got %b%b want 00", k, bus_if.imem_req_valid, bus_if.inst_valid); end
            @(negedge clk);
        end
        #1;
        // Response in the last allowed waiting cycle latches normally.
        d = $urandom;
        do_reset();
        bus_if.imem_req_ready = 1'b1;
        @(negedge clk);
        bus_if.imem_req_ready = 1'b0;
        #1;
        for (int k = 1; k < int'(TIMEOUT); k++) begin
            @(negedge clk);
            #1;
        end
        bus_if.imem_rsp_valid = 1'b1;
        bus_if.imem_rsp_data  = d;
        @(negedge clk);
        bus_if.imem_rsp_valid = 1'b0;
        #1;
        tests_run++; if (fetch_error !== 1'b0) begin tests_failed++; $display("FAIL to_edge_err: got %b want 0", fetch_error); end
        tests_run++; if (bus_if.inst_valid !== 1'b1 || bus_if.inst_out !== d) begin tests_failed++; $display("FAIL to_edge_latch: got %b/%h want 1/%h", bus_if.inst_valid, bus_if.inst_out, d); end
        idle_inputs();
    endtask

    task automatic test_halt_wait();
        logic [31:0] d;
        d = $urandom;
        do_reset();
        bus_if.imem_req_ready = 1'b1;
        @(negedge clk);
        bus_if.imem_req_ready = 1'b0;
        halt                  = 1'b1;
        bus_if.imem_rsp_valid = 1'b1;
        bus_if.imem_rsp_data  = d;
        @(negedge clk);
        bus_if.imem_rsp_valid = 1'b0;
        #1;
        tests_run++; if (bus_if.inst_valid !== 1'b1 || bus_if.inst_out !== d) begin tests_failed++; $display("FAIL hw_latch: got %b/%h want 1/%h", bus_if.inst_valid, bus_if.inst_out, d); end
        npc_off           = 32'd7;
        bus_if.inst_ready = 1'b1;
        @(negedge clk);
        bus_if.inst_ready = 1'b0;
        #1;
        tests_run++; if (program_counter !== 32'd7) begin tests_failed++; $display("FAIL hw_pc: got %h want 7", program_counter); end
        for (int k = 0; k < 4; k++) begin
            tests_run++; if (bus_if.imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL hw_no_req k=%0d: got %b want 0", k, bus_if.imem_req_valid); end
            @(negedge clk);
            #1;
        end
        halt = 1'b0;
        #1;
        tests_run++; if (bus_if.imem_req_valid !== 1'b1 || bus_if.imem_addr !== 32'd7) begin tests_failed++; $display("FAIL hw_resume: got %b/%h want 1/7", bus_if.imem_req_valid, bus_if.imem_addr); end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [31:0] d2;
        d2 = $urandom;
        do_reset();
        run_to_hold(32'hAAAA_5555, ok);
        npc_off           = 32'd5;
        bus_if.inst_ready = 1'b1;
        @(negedge clk);
        bus_if.inst_ready     = 1'b0;
        bus_if.imem_req_ready = 1'b1;
        @(negedge clk);
        bus_if.imem_req_ready = 1'b0;
        reset                 = 1'b1;
        #1;
        tests_run++; if (bus_if.imem_req_valid !== 1'b0 || bus_if.inst_valid !== 1'b0) begin tests_failed++; $display("FAIL rm_forced: got %b%b want 00", bus_if.imem_req_valid, bus_if.inst_valid); end
        @(negedge clk);
        reset                 = 1'b0;
        bus_if.imem_rsp_valid = 1'b1;
        bus_if.imem_rsp_data  = 32'hDEAD_BEEF;
        #1;
        tests_run++; if (program_counter !== 32'd0) begin tests_failed++; $display("FAIL rm_pc: got %h want 0", program_counter); end
        tests_run++; if (bus_if.inst_valid !== 1'b0) begin tests_failed++; $display("FAIL rm_inst_valid: got %b want 0", bus_if.inst_valid); end
        tests_run++; if (bus_if.imem_req_valid !== 1'b1 || bus_if.imem_addr !== 32'd0) begin tests_failed++; $display("FAIL rm_req: got %b/%h want 1/0", bus_if.imem_req_valid, bus_if.imem_addr); end
        @(negedge clk);
        bus_if.imem_rsp_valid = 1'b0;
        #1;
        tests_run++; if (bus_if.inst_valid !== 1'b0 || bus_if.imem_req_valid !== 1'b1) begin tests_failed++; $display("FAIL rm_late_rsp: got %b%b want 01", bus_if.inst_valid, bus_if.imem_req_valid); end
        run_to_hold(d2, ok);
        tests_run++; if (!ok || bus_if.inst_pc !== 32'd0 || bus_if.inst_out !== d2) begin tests_failed++; $display("FAIL rm_refetch: got %h/%h want 0/%h", bus_if.inst_pc, bus_if.inst_out, d2); end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [31:0] model_pc;
        bit          outstanding;
        int          wait_cnt;
        bit          held;
        bit          exp_req;
        do_reset();
        model_pc    = 32'd0;
        outstanding = 1'b0;
        wait_cnt    = 0;
        exp_q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            halt                  = ($urandom_range(0, 3) == 0);
            bus_if.imem_req_ready = 1'($urandom_range(0, 1));
            bus_if.inst_ready     = ($urandom_range(0, 2) != 0);
            npc_off               = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(1, 3));
            bus_if.imem_rsp_data  = $urandom;
            if (outstanding && wait_cnt == 0) begin
                bus_if.imem_rsp_valid = 1'b1;
            end else begin
                bus_if.imem_rsp_valid = !outstanding && ($urandom_range(0, 4) == 0);
                if (outstanding) wait_cnt--;
            end
            #1;
            held    = (exp_q.size() != 0);
            exp_req = !outstanding && !held && !halt;
            tests_run++; if (program_counter !== model_pc) begin tests_failed++; $display("FAIL rnd_pc cyc=%0d: got %h want %h", cyc, program_counter, model_pc); end
            tests_run++; if (bus_if.imem_req_valid !== exp_req) begin tests_failed++; $display("FAIL rnd_req cyc=%0d: got %b want %b", cyc, bus_if.imem_req_valid, exp_req); end
            tests_run++; if (bus_if.inst_valid !== held) begin tests_failed++; $display("FAIL rnd_inst_valid cyc=%0d: got %b want %b", cyc, bus_if.inst_valid, held); end
            if (exp_req) begin
                tests_run++; if (bus_if.imem_addr !== model_pc) begin tests_failed++; $display("FAIL rnd_addr cyc=%0d: got %h want %h", cyc, bus_if.imem_addr, model_pc); end
            end
            if (held) begin
                tests_run++; if ({bus_if.inst_pc, bus_if.inst_out} !== exp_q[0]) begin tests_failed++; $display("FAIL rnd_inst cyc=%0d: got %h/%h want %h", cyc, bus_if.inst_pc, bus_if.inst_out, exp_q[0]); end
            end
            tests_run++; if (fetch_error !== 1'b0) begin tests_failed++; $display("FAIL rnd_err cyc=%0d: got %b want 0", cyc, fetch_error); end
            if (outstanding && bus_if.imem_rsp_valid) begin
                exp_q.push_back({model_pc, bus_if.imem_rsp_data});
                outstanding = 1'b0;
            end else if (exp_req && bus_if.imem_req_ready) begin
                outstanding = 1'b1;
                wait_cnt    = $urandom_range(0, 8);
            end
            if (held && bus_if.inst_ready) begin
                void'(exp_q.pop_front());
                model_pc = model_pc + npc_off;
            end
            @(negedge clk);
        end
        #1;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_zero_wait();
        test_branch();
        test_backpressure();
        test_timeout();
        test_halt_wait();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
